// File: rtl/iq_sweep_pkg.sv
// Shared types and default sizes for the IQ frequency-sweep controller.
package iq_sweep_pkg;

    localparam int DEF_DW     = 14;  // signed I/Q sample width
    localparam int DEF_PW     = 32;  // NCO phase increment width
    localparam int DEF_NPW    = 16;  // point count/index width
    localparam int DEF_SCW    = 20;  // settle counter width
    localparam int DEF_MAXLOG = 15;  // largest accepted avg_log2
    localparam int ACCW       = DEF_DW + DEF_MAXLOG;  // accumulator width that cannot overflow

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        EMIT
    } state_t;

    // Limit the requested averaging exponent to what the accumulators can hold.
    function automatic logic [3:0] clamp_log2(input logic [3:0] v, input int max_log);
        return (int'(v) > max_log) ? 4'(max_log) : v;
    endfunction

endpackage

// File: rtl/iq_avg_accum.sv
// Dual signed I/Q accumulator with sample counter and power-of-two averaging output.
module iq_avg_accum import iq_sweep_pkg::*; #(
    parameter int DW     = DEF_DW,
    parameter int MAXLOG = DEF_MAXLOG
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  logic [3:0]    shift,
    input  logic [DW-1:0] i_in,
    input  logic [DW-1:0] q_in,
    output logic          full,
    output logic [DW-1:0] avg_i,
    output logic [DW-1:0] avg_q
);

    localparam int AW   = DW + MAXLOG;
    localparam int CNTW = MAXLOG + 1;

    logic signed [AW-1:0] acc_i;
    logic signed [AW-1:0] acc_q;
    logic [CNTW-1:0]      sample_cnt;
    logic [CNTW-1:0]      target;

    assign target = CNTW'(1) << shift;

    // Asserted on the cycle whose accepted sample completes the set, so the
    // controller can leave CAPTURE on that same edge.
    assign full = en && (sample_cnt == target - CNTW'(1));

    // Arithmetic shift floors toward -inf; only the low DW bits are kept.
    assign avg_i = DW'(acc_i >>> shift);
    assign avg_q = DW'(acc_q >>> shift);

    // Accumulate sign-extended samples on every qualified cycle.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset || clear) begin
            acc_i      <= '0;
            acc_q      <= '0;
            sample_cnt <= '0;
        end else if (en) begin
            acc_i      <= acc_i + $signed({{MAXLOG{i_in[DW-1]}}, i_in});
            acc_q      <= acc_q + $signed({{MAXLOG{q_in[DW-1]}}, q_in});
            sample_cnt <= sample_cnt + CNTW'(1);
        end
    end

endmodule

// File: rtl/iq_sweep_controller.sv
// Frequency-sweep sequencer: steps the NCO phase increment, waits for the
// filter to settle, averages I/Q and emits one result per sweep point.
module iq_sweep_controller import iq_sweep_pkg::*; #(
    parameter int DW     = DEF_DW,
    parameter int PW     = DEF_PW,
    parameter int NPW    = DEF_NPW,
    parameter int SCW    = DEF_SCW,
    parameter int MAXLOG = DEF_MAXLOG
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [PW-1:0]  start_inc,
    input  logic [PW-1:0]  step_inc,
    input  logic [NPW-1:0] num_points,
    input  logic [SCW-1:0] settle_cycles,
    input  logic [3:0]     avg_log2,
    input  logic [DW-1:0]  i_in,
    input  logic [DW-1:0]  q_in,
    input  logic           iq_valid,
    output logic [PW-1:0]  phase_inc,
    output logic [DW-1:0]  result_i,
    output logic [DW-1:0]  result_q,
    output logic [NPW-1:0] result_idx,
    output logic           result_valid,
    output logic           busy,
    output logic           done
);

    state_t         state;
    state_t         state_next;

    logic [PW-1:0]  step_r;
    logic [NPW-1:0] npts_r;
    logic [SCW-1:0] settle_r;
    logic [3:0]     avg_r;
    logic [SCW-1:0] settle_cnt;
    logic [NPW-1:0] point;
    logic           done_pend;

    logic           accept_start;
    logic           zero_start;
    logic           settle_dec;
    logic           emit;
    logic           last_point;
    logic           acc_clear;
    logic           acc_en;
    logic           acc_full;
    logic [DW-1:0]  avg_i;
    logic [DW-1:0]  avg_q;

    assign busy       = (state != IDLE);
    assign last_point = (point == npts_r - NPW'(1));
    // Kept outside the FSM block: acc_full depends on acc_en combinationally.
    assign acc_en     = (state == CAPTURE) && iq_valid;

    iq_avg_accum #(
        .DW     (DW),
        .MAXLOG (MAXLOG)
    ) u_accum (
        .CLK   (CLK),
        .reset (reset),
        .clear (acc_clear),
        .en    (acc_en),
        .shift (avg_r),
        .i_in  (i_in),
        .q_in  (q_in),
        .full  (acc_full),
        .avg_i (avg_i),
        .avg_q (avg_q)
    );

    // Next-state and per-cycle control strobes; abort overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next   = state;
        accept_start = 1'b0;
        zero_start   = 1'b0;
        settle_dec   = 1'b0;
        emit         = 1'b0;
        acc_clear    = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_points != '0) begin
                            accept_start = 1'b1;
                            state_next   = SETTLE;
                        end else begin
                            zero_start = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        acc_clear  = 1'b1;
                        state_next = CAPTURE;
                    end else begin
                        settle_dec = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (acc_full) state_next = EMIT;
                end
                EMIT: begin
                    emit       = 1'b1;
                    state_next = last_point ? IDLE : SETTLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register, configuration latch, settle/point counters and result outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= IDLE;
            step_r       <= '0;
            npts_r       <= '0;
            settle_r     <= '0;
            avg_r        <= '0;
            settle_cnt   <= '0;
            point        <= '0;
            done_pend    <= 1'b0;
            phase_inc    <= '0;
            result_i     <= '0;
            result_q     <= '0;
            result_idx   <= '0;
            result_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            result_valid <= 1'b0;
            done         <= done_pend | zero_start;
            done_pend    <= 1'b0;

            if (accept_start) begin
                phase_inc  <= start_inc;
                step_r     <= step_inc;
                npts_r     <= num_points;
                settle_r   <= settle_cycles;
                avg_r      <= clamp_log2(avg_log2, MAXLOG);
                settle_cnt <= settle_cycles;
                point      <= '0;
            end

            if (settle_dec) settle_cnt <= settle_cnt - SCW'(1);

            if (emit) begin
                result_i     <= avg_i;
                result_q     <= avg_q;
                result_idx   <= point;
                result_valid <= 1'b1;
                if (last_point) begin
                    done_pend <= 1'b1;
                end else begin
                    point      <= point + NPW'(1);
                    phase_inc  <= phase_inc + step_r;
                    settle_cnt <= settle_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_sweep_controller.sv
// Directed self-checking bench for iq_sweep_controller.
module tb_iq_sweep_controller;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] start_inc;
    logic [31:0] step_inc;
    logic [15:0] num_points;
    logic [19:0] settle_cycles;
    logic [3:0]  avg_log2;
    logic [13:0] i_in;
    logic [13:0] q_in;
    logic        iq_valid;
    logic [31:0] phase_inc;
    logic [13:0] result_i;
    logic [13:0] result_q;
    logic [15:0] result_idx;
    logic        result_valid;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    int n;
    int n_rv;
    int n_done;

    iq_sweep_controller dut (
        .CLK           (CLK),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .start_inc     (start_inc),
        .step_inc      (step_inc),
        .num_points    (num_points),
        .settle_cycles (settle_cycles),
        .avg_log2      (avg_log2),
        .i_in          (i_in),
        .q_in          (q_in),
        .iq_valid      (iq_valid),
        .phase_inc     (phase_inc),
        .result_i      (result_i),
        .result_q      (result_q),
        .result_idx    (result_idx),
        .result_valid  (result_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold start high across one rising edge; returns on the falling edge after it.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Count rising edges until result_valid is seen, bounded by budget.
    task automatic wait_strobe(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge CLK);
            cycles++;
        end while (!result_valid && cycles < budget);
    endtask

    // Count result_valid and done pulses over a fixed window.
    task automatic watch(input int cycles, output int rv_cnt, output int done_cnt);
        rv_cnt   = 0;
        done_cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge CLK);
            if (result_valid) rv_cnt++;
            if (done) done_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        start_inc = '0; step_inc = '0; num_points = '0; settle_cycles = '0;
        avg_log2 = '0; i_in = '0; q_in = '0; iq_valid = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_phase", phase_inc, 0);
        check("rst_busy", busy, 0);
        check("rst_rv", result_valid, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(negedge CLK);

        // Basic 3-point sweep, constant input.
        start_inc = 32'd85899346; step_inc = 32'd8589935; num_points = 16'd3;
        settle_cycles = 20'd10; avg_log2 = 4'd2; iq_valid = 1'b1;
        i_in = 14'(100); q_in = 14'(-100);
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_ph0", phase_inc, 85899346);
        wait_strobe(40, n);
        check("t1_lat0", n, 16);
        check("t1_idx0", result_idx, 0);
        check("t1_i0", $signed(result_i), 100);
        check("t1_q0", $signed(result_q), -100);
        check("t1_ph1", phase_inc, 94489281);
        wait_strobe(40, n);
        check("t1_lat1", n, 16);
        check("t1_idx1", result_idx, 1);
        check("t1_ph2", phase_inc, 103079216);
        wait_strobe(40, n);
        check("t1_lat2", n, 16);
        check("t1_idx2", result_idx, 2);
        check("t1_q2", $signed(result_q), -100);
        check("t1_ph_hold", phase_inc, 103079216);
        check("t1_busy_end", busy, 0);
        check("t1_done_early", done, 0);
        @(negedge CLK);
        check("t1_done", done, 1);
        watch(20, n_rv, n_done);
        check("t1_extra_rv", n_rv, 0);
        check("t1_extra_done", n_done, 0);

        // Floor rounding with gaps in iq_valid.
        num_points = 16'd1; settle_cycles = 20'd0; avg_log2 = 4'd1; iq_valid = 1'b0;
        pulse_start();
        iq_valid = 1'b0; @(negedge CLK);
        iq_valid = 1'b1; i_in = 14'(3);   q_in = 14'(5);   @(negedge CLK);
        iq_valid = 1'b0; i_in = 14'(100); q_in = 14'(100); @(negedge CLK);
        iq_valid = 1'b1; i_in = 14'(-4);  q_in = 14'(6);   @(negedge CLK);
        iq_valid = 1'b0;
        check("t2_rv_early", result_valid, 0);
        @(negedge CLK);
        check("t2_rv", result_valid, 1);
        check("t2_i", $signed(result_i), -1);
        check("t2_q", $signed(result_q), 5);
        @(negedge CLK);
        check("t2_done", done, 1);

        // Zero-length sweep.
        num_points = 16'd0;
        pulse_start();
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        check("t3_rv", result_valid, 0);
        @(negedge CLK);
        check("t3_done_clr", done, 0);
        check("t3_busy2", busy, 0);

        // Abort during CAPTURE of point 1, then a clean restart.
        start_inc = 32'd1000; step_inc = 32'd250; num_points = 16'd4;
        settle_cycles = 20'd2; avg_log2 = 4'd2; iq_valid = 1'b1;
        i_in = 14'(40); q_in = 14'(-40);
        pulse_start();
        wait_strobe(40, n);
        check("t4_lat0", n, 8);
        check("t4_i0", $signed(result_i), 40);
        repeat (5) @(negedge CLK);
        check("t4_busy_cap", busy, 1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("t4_busy_abort", busy, 0);
        check("t4_ph_hold", phase_inc, 1250);
        watch(40, n_rv, n_done);
        check("t4_no_rv", n_rv, 0);
        check("t4_no_done", n_done, 0);
        start_inc = 32'd5000; num_points = 16'd2; i_in = 14'(-7); q_in = 14'(9);
        pulse_start();
        check("t4_ph_new", phase_inc, 5000);
        wait_strobe(40, n);
        check("t4_lat_new", n, 8);
        check("t4_idx_new", result_idx, 0);
        check("t4_i_new", $signed(result_i), -7);
        check("t4_q_new", $signed(result_q), 9);
        start_inc = 32'd7777; num_points = 16'd9;
        pulse_start();
        check("t4_start_busy_ign", phase_inc, 5250);
        wait_strobe(40, n);
        check("t4_idx_last", result_idx, 1);
        @(negedge CLK);
        check("t4_done", done, 1);

        // Phase increment wraps modulo 2^32.
        start_inc = 32'hFFFF_FFF0; step_inc = 32'h20; num_points = 16'd2;
        settle_cycles = 20'd0; avg_log2 = 4'd0; i_in = 14'(100); q_in = 14'(-3);
        pulse_start();
        wait_strobe(20, n);
        check("t5_lat0", n, 3);
        check("t5_ph_wrap", phase_inc, 32'h10);
        wait_strobe(20, n);
        check("t5_lat1", n, 3);
        check("t5_idx1", result_idx, 1);
        @(negedge CLK);
        check("t5_done", done, 1);

        // Reset mid-SETTLE with start pulsing on the same edge.
        start_inc = 32'd123; num_points = 16'd2; settle_cycles = 20'd10; avg_log2 = 4'd2;
        pulse_start();
        repeat (3) @(negedge CLK);
        reset = 1'b1; start = 1'b1;
        @(negedge CLK);
        reset = 1'b0; start = 1'b0;
        check("t6_phase", phase_inc, 0);
        check("t6_ri", result_i, 0);
        check("t6_rq", result_q, 0);
        check("t6_idx", result_idx, 0);
        check("t6_rv", result_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        @(negedge CLK);
        check("t6_stay_idle", busy, 0);

        // Full-scale input with the deepest averaging.
        num_points = 16'd1; settle_cycles = 20'd0; avg_log2 = 4'd15; iq_valid = 1'b1;
        i_in = 14'(8191); q_in = 14'(-8192);
        pulse_start();
        wait_strobe(40000, n);
        check("t6_lat_fs", n, 32770);
        check("t6_i_fs", $signed(result_i), 8191);
        check("t6_q_fs", $signed(result_q), -8192);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iq_sweep_controller.md
Name: iq_sweep_controller

Overview:
Frequency-sweep sequencer for one IQModule mixer. It steps the NCO phase increment across a programmed range. After each step it waits a settle time so the FIR output reflects the new frequency, then averages 2^avg_log2 valid I/Q samples and emits one averaged I/Q result per point. It sits between the physical controls/host logic and the IQModule phaseInc/I/Q ports, replacing a fixed phaseInc constant.

Parameters:
DW, 14, signed width of I/Q samples and results
PW, 32, phase increment width (NCO phi_inc)
NPW, 16, width of point count/index
SCW, 20, width of settle cycle counter (max ~21 ms at 50 MHz)
MAXLOG, 15, maximum avg_log2 value accepted

Ports:
CLK  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins sweep when idle
abort  in  1  single-cycle pulse; terminates sweep
start_inc  in  PW  phase increment of point 0
step_inc  in  PW  phase increment added per point (unsigned, wraps mod 2^PW)
num_points  in  NPW  points in sweep
settle_cycles  in  SCW  CLK cycles to wait after each phase_inc change
avg_log2  in  4  log2 of samples averaged per point (values >MAXLOG clamp to MAXLOG)
i_in  in  DW  signed I from IQModule
q_in  in  DW  signed Q from IQModule
iq_valid  in  1  I/Q sample qualifier (filter valid)
phase_inc  out  PW  drives IQModule phaseInc
result_i  out  DW  averaged I for current point
result_q  out  DW  averaged Q for current point
result_idx  out  NPW  point index of result
result_valid  out  1  one-cycle strobe with result_*
busy  out  1  high in any state except IDLE
done  out  1  one-cycle strobe on normal sweep completion

Behaviour:
- Reset: state IDLE; phase_inc=0, result_i=0, result_q=0, result_idx=0, result_valid=0, busy=0, done=0; all counters and accumulators cleared. Reset applies on the same edge, mid-sweep included.
- Config latch: start_inc, step_inc, num_points, settle_cycles and clamped avg_log2 are registered on the accepted start cycle. Input changes during a sweep are ignored.
- States: IDLE, SETTLE, CAPTURE, EMIT.
- IDLE, start=1, num_points!=0: phase_inc<=start_inc, point<=0, settle_cnt<=settle_cycles, go to SETTLE.
- IDLE, start=1, num_points==0: done pulses the next cycle, stay IDLE, no results.
- SETTLE: decrement settle_cnt each cycle. When it reaches 0 (or was 0 on entry), clear accumulators and sample count, then go to CAPTURE. settle_cycles=0 means CAPTURE is entered one cycle after the phase_inc update.
- CAPTURE: on each iq_valid=1 cycle, acc_i+=sext(i_in) and acc_q+=sext(q_in); accumulators are DW+MAXLOG bits signed, so no overflow. Cycles with iq_valid=0 are not counted. After 2^avg_log2 samples, go to EMIT.
- EMIT (one cycle): result_i/q<=acc>>>avg_log2 (arithmetic shift, truncate toward -inf, low DW bits); result_idx<=point; result_valid=1.
  - If point==num_points-1: done=1 and go to IDLE. phase_inc holds its last value.
  - Else: point+1, phase_inc<=phase_inc+step_inc (mod 2^PW), reload settle_cnt, go to SETTLE.
- abort: highest priority after reset; from any non-IDLE state go to IDLE next cycle. No result_valid or done is produced; phase_inc holds.
- start while busy: ignored. start and abort in the same cycle in IDLE: abort wins, start ignored.
- result_* hold their value between strobes.

Decomposition:
- Package iq_sweep_pkg: state enum (IDLE, SETTLE, CAPTURE, EMIT), DW/PW/NPW/SCW/MAXLOG defaults, and accumulator width constant ACCW=DW+MAXLOG.
- One sub-module: iq_avg_accum. It holds the dual signed accumulators, sample counter, shift/truncate output, and clear/enable/full handshake; it is instantiated once.
- FSM, settle counter and phase stepping live in the top module.

Test Plan:
- start_inc=85899346, step_inc=8589935, num_points=3, settle=10, avg_log2=2, iq_valid always 1, I=100, Q=-100: exactly 3 result_valid strobes with idx 0,1,2 and I=100, Q=-100; phase_inc sequence 85899346, 94489281, 103079216; done 1 cycle after the 3rd strobe; first strobe 16 cycles after start.
- avg_log2=1, samples I=3 then I=-4 with iq_valid on alternate cycles: result_i=-1 (floor of -0.5); invalid cycles are not counted, verified by strobe timing.
- num_points=0 with start: done pulses once, busy stays 0, no result_valid.
- Abort during CAPTURE of point 1 of 4: busy drops next cycle, no further result_valid, no done; a new start afterwards runs cleanly from idx 0.
- start_inc=32'hFFFF_FFF0, step_inc=32'h20, 2 points: phase_inc wraps to 32'h10 for point 1.
- Reset asserted mid-SETTLE with start pulsing the same cycle: all outputs return to reset values and the FSM stays IDLE; avg_log2=15 with full-scale I=8191 gives result_i=8191 (no accumulator overflow).
